quantizer_pipeline: RTL and testbench
=====================================

QUANTIZER_PIPELINE -- requirements
Module: quantizer_pipeline

Interface
REQ-001 SHALL have parameter QUANTIZER_SIZE, default 64, meaning number of parallel lanes.
REQ-002 SHALL have parameter ACCUMULATOR_DATA_WIDTH, default 16, meaning signed input lane width.
REQ-003 SHALL have parameter COMPUTE_DATA_WIDTH, default 4, meaning signed output lane width; the legal range is 2..ACCUMULATOR_DATA_WIDTH-1.
REQ-004 SHALL have parameter SHIFT_WIDTH, default $clog2(ACCUMULATOR_DATA_WIDTH), meaning width of the shift field.
REQ-005 SHALL have parameter SAT_COUNT_WIDTH, default 16, meaning width of the saturation counter.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-010 SHALL have port ins, input, signed [ACCUMULATOR_DATA_WIDTH-1:0] x QUANTIZER_SIZE: the accumulator lanes.
REQ-011 SHALL have port shift, input, [SHIFT_WIDTH-1:0]: arithmetic right-shift amount.
REQ-012 SHALL have port round_en, input, 1 bit: 1 = round half away from zero, 0 = truncate toward minus infinity.
REQ-013 SHALL have port zero_point, input, signed [COMPUTE_DATA_WIDTH-1:0]: offset added after the shift.
REQ-014 SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-016 SHALL have port results, output, signed [COMPUTE_DATA_WIDTH-1:0] x QUANTIZER_SIZE: the quantized lanes.
REQ-017 SHALL have port sat_flags, output, [QUANTIZER_SIZE-1:0]: per-lane saturation flag for the beat currently on results.
REQ-018 SHALL have port sat_count, output, [SAT_COUNT_WIDTH-1:0]: number of accepted output beats with any lane saturated.
REQ-019 SHALL have port sat_clear, input, 1 bit: synchronous clear of sat_count.

Function
REQ-020 SHALL sample ins, shift, round_en and zero_point together on the in_valid && in_ready handshake; config changes SHALL affect only beats accepted afterwards.
REQ-021 SHALL use a two-stage pipeline: S1 registers the shifted/rounded value at ACCUMULATOR_DATA_WIDTH+1 bits; S2 registers the zero-point add, saturation, results and sat_flags.
REQ-022 SHALL have a latency of exactly 2 cycles from the input handshake to out_valid when no backpressure occurs.
REQ-023 SHALL compute shifted = in >>> shift when round_en=0.
REQ-024 SHALL compute shifted = (|in| + 2^(shift-1)) >> shift, with the sign of in reapplied, when round_en=1 and shift>0.
REQ-025 SHALL make round_en irrelevant when shift=0 (shifted = in).
REQ-026 SHALL treat shift >= ACCUMULATOR_DATA_WIDTH as shift = ACCUMULATOR_DATA_WIDTH-1.
REQ-027 SHALL compute sum = shifted + sign-extended zero_point without overflow, and clamp it to [-2^(COMPUTE_DATA_WIDTH-1), 2^(COMPUTE_DATA_WIDTH-1)-1].
REQ-028 SHALL set sat_flags[i]=1 exactly when lane i was clamped.
REQ-029 SHALL implement a stall-free handshake: each stage loads when empty or when its contents move on in the same cycle; in_ready = !S1_valid || S1 advances.
REQ-030 SHALL provide full throughput: one beat per cycle while out_ready=1.
REQ-031 SHALL hold results, sat_flags and out_valid stable while out_valid && !out_ready.
REQ-032 SHALL never drop or duplicate a beat; with both stages full and out_ready=0, in_ready SHALL be 0.
REQ-033 SHALL increment sat_count by 1 on each output handshake with |sat_flags, saturating at all-ones with no wrap.
REQ-034 SHALL give sat_clear priority over a simultaneous increment: the result is 0.

Reset
REQ-035 SHALL, while rst_n=0, immediately force out_valid=0, the S1 and S2 valid bits=0, sat_count=0, results=0 and sat_flags=0.
REQ-036 SHALL drive in_ready=1 during and after reset.
REQ-037 SHALL discard in-flight beats on a mid-operation reset; after deassertion the first out_valid SHALL be no earlier than 2 cycles after the first accepted beat.

Verification
REQ-038 SHALL cover: ins lane=100, shift=3, round_en=0, zp=0, widths 16/4 -> result 7 (12 clamped), sat_flag=1, out_valid at cycle +2.
REQ-039 SHALL cover: ins=-5, shift=1, round_en=1, zp=0 -> -3; with round_en=0 -> -3; ins=5, round_en=0 -> 2; round_en=1 -> 3, all flags 0.
REQ-040 SHALL cover: ins=-200, shift=4, zp=-3 -> -8 clamped with flag; ins=0, zp=2 -> 2, no flag.
REQ-041 SHALL cover: a 10-beat stream with out_ready=0 for cycles 3-6 -> in_ready drops after both stages fill, results are stable while stalled, and the output order matches input with no loss.
REQ-042 SHALL cover: sat_count preloaded to all-ones by 2^SAT_COUNT_WIDTH saturating beats (use SAT_COUNT_WIDTH=4) -> it stays at 15; sat_clear together with a saturating handshake -> 0.
REQ-043 SHALL cover: rst_n pulsed low with both stages full -> out_valid=0 asynchronously, sat_count=0, and no stale beat emerges afterwards.

Source files
------------

// File: rtl/quantizer_pipeline.sv
// Two-stage per-lane requantizer: arithmetic shift (optionally rounded),
// zero-point offset and saturation, with a valid/ready handshake and a
// saturating count of output beats that contained any clamped lane.
module quantizer_pipeline #(
  parameter int QUANTIZER_SIZE         = 64,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int COMPUTE_DATA_WIDTH     = 4,
  parameter int SHIFT_WIDTH            = $clog2(ACCUMULATOR_DATA_WIDTH),
  parameter int SAT_COUNT_WIDTH        = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] ins [QUANTIZER_SIZE],
  input  logic        [SHIFT_WIDTH-1:0]            shift,
  input  logic                                     round_en,
  input  logic signed [COMPUTE_DATA_WIDTH-1:0]     zero_point,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [COMPUTE_DATA_WIDTH-1:0]     results [QUANTIZER_SIZE],
  output logic        [QUANTIZER_SIZE-1:0]         sat_flags,
  output logic        [SAT_COUNT_WIDTH-1:0]        sat_count,
  input  logic                                     sat_clear
);

  localparam int AW = ACCUMULATOR_DATA_WIDTH;
  localparam int CW = COMPUTE_DATA_WIDTH;
  localparam int QS = QUANTIZER_SIZE;
  localparam logic signed [AW+1:0] QMAX = (AW+2)'(2**(CW-1) - 1);
  localparam logic signed [AW+1:0] QMIN = ~QMAX;

  // Shift one lane; rounding works on the magnitude so halves go away from zero.
  // The extra bit keeps |-2^(AW-1)| and the rounding carry representable.
  function automatic logic signed [AW:0] scale_lane(
    input logic signed [AW-1:0]          v,
    input logic        [SHIFT_WIDTH-1:0] s,
    input logic                          rnd
  );
    logic signed [AW:0] x;
    logic        [AW:0] m;
    logic        [AW:0] half;
    x = {v[AW-1], v};
    if (!rnd || s == '0) begin
      return x >>> s;
    end
    m    = x[AW] ? $unsigned(-x) : $unsigned(x);
    half = {{AW{1'b0}}, 1'b1} << (s - 1'b1);
    m    = (m + half) >> s;
    return x[AW] ? -$signed(m) : $signed(m);
  endfunction

  logic                     s1_valid;
  logic signed [AW:0]       s1_val [QS];
  logic signed [CW-1:0]     s1_zp;
  logic                     s1_adv;
  logic                     s2_load;
  logic [SHIFT_WIDTH-1:0]   eff_shift;
  logic signed [AW:0]       s1_next [QS];
  logic signed [AW+1:0]     sum [QS];
  logic signed [CW-1:0]     res_next [QS];
  logic [QS-1:0]            flag_next;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;

  // Clamp oversize shift amounts, then compute the stage-1 lane values.
  always_comb begin
    eff_shift = (int'(shift) >= AW) ? SHIFT_WIDTH'(AW - 1) : shift;
    for (int unsigned i = 0; i < QS; i++) begin
      s1_next[i] = scale_lane(ins[i], eff_shift, round_en);
    end
  end

  // Zero-point add at full width, then saturate to the output lane range.
  always_comb begin
    flag_next = '0;
    for (int unsigned i = 0; i < QS; i++) begin
      sum[i] = {s1_val[i][AW], s1_val[i]} + {{(AW+2-CW){s1_zp[CW-1]}}, s1_zp};
      if (sum[i] > QMAX) begin
        res_next[i]  = QMAX[CW-1:0];
        flag_next[i] = 1'b1;
      end else if (sum[i] < QMIN) begin
        res_next[i]  = QMIN[CW-1:0];
        flag_next[i] = 1'b1;
      end else begin
        res_next[i]  = sum[i][CW-1:0];
      end
    end
  end

  // Stage 1: capture shifted lanes and the beat's zero point on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_zp    <= '0;
      for (int unsigned i = 0; i < QS; i++) s1_val[i] <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_zp <= zero_point;
        for (int unsigned i = 0; i < QS; i++) s1_val[i] <= s1_next[i];
      end
    end
  end

  // Stage 2: saturated results and flags, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sat_flags <= '0;
      for (int unsigned i = 0; i < QS; i++) results[i] <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sat_flags <= flag_next;
        for (int unsigned i = 0; i < QS; i++) results[i] <= res_next[i];
      end
    end
  end

  // Count delivered beats with any clamped lane; clear wins, no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && (|sat_flags) && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_quantizer_pipeline.sv
// Scoreboard bench for quantizer_pipeline: directed vectors push expected
// beats on input handshake; a negedge monitor pops and compares each output.
module tb_quantizer_pipeline;

  localparam int QS = 4;

  typedef struct packed {
    logic [3:0][3:0] res;
    logic [3:0]      flags;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] ins [QS];
  logic        [4:0]  shift = '0;
  logic               round_en = 1'b0;
  logic signed [3:0]  zero_point = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [3:0]  results [QS];
  logic        [3:0]  sat_flags;
  logic        [3:0]  sat_count;
  logic               sat_clear = 1'b0;

  int   checks = 0;
  int   passes = 0;
  exp_t expq[$];

  logic        stalled = 1'b0;
  logic [15:0] held_res;
  logic [3:0]  held_flags;

  quantizer_pipeline #(
    .QUANTIZER_SIZE(QS),
    .ACCUMULATOR_DATA_WIDTH(16),
    .COMPUTE_DATA_WIDTH(4),
    .SHIFT_WIDTH(5),
    .SAT_COUNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ins(ins), .shift(shift), .round_en(round_en), .zero_point(zero_point),
    .out_valid(out_valid), .out_ready(out_ready),
    .results(results), .sat_flags(sat_flags),
    .sat_count(sat_count), .sat_clear(sat_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    checks++;
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got == expv) passes++;
    else $display("FAIL %s got %0d expected %0d", name, got, expv);
  endtask

  function automatic int clampq(input int v);
    return (v > 7) ? 7 : ((v < -8) ? -8 : v);
  endfunction

  // Present one beat, wait (bounded) for its handshake, then record the expectation.
  task automatic send(input int a0, input int a1, input int a2, input int a3,
                      input int sh, input bit rnd, input int zp,
                      input int e0, input int e1, input int e2, input int e3,
                      input logic [3:0] ef);
    exp_t e;
    bit   hs;
    int   n;
    ins[0] = 16'(a0); ins[1] = 16'(a1); ins[2] = 16'(a2); ins[3] = 16'(a3);
    shift = 5'(sh); round_en = rnd; zero_point = 4'(zp);
    in_valid = 1'b1;
    e.res = {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    e.flags = ef;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (hs) expq.push_back(e);
    else begin
      checks++;
      $display("FAIL in_handshake timed out waiting for in_ready");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_queue_empty", expq.size(), 0);
  endtask

  // Monitor: output beats against the scoreboard, and stability while stalled.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] got;
    got = {results[3], results[2], results[1], results[0]};
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        if (out_valid === 1'b1 && got === held_res && sat_flags === held_flags) passes++;
        else $display("FAIL stall_hold got v=%b res=%h flags=%b expected v=1 res=%h flags=%b",
                      out_valid, got, sat_flags, held_res, held_flags);
      end
      stalled    = out_valid && !out_ready;
      held_res   = got;
      held_flags = sat_flags;
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          $display("FAIL unexpected_beat got res=%h flags=%b with nothing expected", got, sat_flags);
        end else begin
          e = expq.pop_front();
          if (got === e.res && sat_flags === e.flags) passes++;
          else $display("FAIL beat got res=%h flags=%b expected res=%h flags=%b",
                        got, sat_flags, e.res, e.flags);
        end
      end
    end
  end

  initial begin
    int n;
    int a0, a1, a2, a3;
    for (int i = 0; i < QS; i++) ins[i] = '0;

    // Reset state
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_sat_flags", int'(sat_flags), 0);
    chk("rst_result0", int'(results[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: handshake edge, then out_valid one edge later (cycle +2)
    send(100, 8, -9, 0, 3, 1'b0, 0, 7, 1, -2, 0, 4'b0001);
    chk("latency_after_accept", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("latency_plus2", int'(out_valid), 1);
    drain();
    chk("sat_count_one", int'(sat_count), 1);

    // Rounding / truncation / zero point / shift-0 / oversize shift
    send(-5, 5, -4, 4, 1, 1'b1, 0, -3, 3, -2, 2, 4'b0000);
    send(-5, 5, -4, 4, 1, 1'b0, 0, -3, 2, -2, 2, 4'b0000);
    send(-200, 0, 50, -1, 4, 1'b0, -3, -8, -3, 0, -4, 4'b0001);
    send(0, 200, -7, 7, 4, 1'b1, 2, 2, 7, 2, 2, 4'b0010);
    send(3, -8, 7, -9, 0, 1'b1, 0, 3, -8, 7, -8, 4'b1000);
    send(-32768, 32767, 16384, -16383, 20, 1'b1, 0, -1, 1, 1, 0, 4'b0000);
    drain();

    // 10-beat stream with downstream stalled for four cycles
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          a0 = k - 5; a1 = k; a2 = -k; a3 = 2 * k - 9;
          send(a0, a1, a2, a3, 0, 1'b0, 0,
               clampq(a0), clampq(a1), clampq(a2), clampq(a3),
               {4'(clampq(a3)) != 4'(a3) || a3 > 7 || a3 < -8,
                a2 < -8, a1 > 7, 1'b0});
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_in_ready_low", int'(in_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Saturation counter: clear, preload past all-ones, then clear vs increment
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    chk("sat_clear_idle", int'(sat_count), 0);
    for (int k = 0; k < 17; k++) send(100, 100, 100, 100, 0, 1'b0, 0, 7, 7, 7, 7, 4'b1111);
    drain();
    chk("sat_count_holds_15", int'(sat_count), 15);
    send(100, 100, 100, 100, 0, 1'b0, 0, 7, 7, 7, 7, 4'b1111);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_race_out_valid", int'(out_valid), 1);
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    chk("sat_clear_priority", int'(sat_count), 0);
    drain();

    // Mid-operation reset with both stages full
    send(-200, 0, 0, 0, 4, 1'b0, 0, -8, 0, 0, 0, 4'b0001);
    drain();
    chk("pre_reset_sat_count", int'(sat_count), 1);
    out_ready = 1'b0;
    send(1, 2, 3, 4, 0, 1'b0, 0, 1, 2, 3, 4, 4'b0000);
    send(5, 6, 7, 8, 0, 1'b0, 0, 5, 6, 7, 7, 4'b1000);
    chk("full_in_ready_low", int'(in_ready), 0);
    chk("full_out_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_sat_count", int'(sat_count), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    chk("async_rst_flags", int'(sat_flags), 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_stale_beat", n, 0);
    @(posedge clk); #1;
    send(-5, 5, -4, 4, 1, 1'b1, 0, -3, 3, -2, 2, 4'b0000);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
